// File: rtl/tt_pkg.sv
// tt_pkg: shared types and constants
// for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam int N_IN_DEF   = 2;
  localparam int SETTLE_DEF = 1;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter,
// expired while the count sits at zero.
module tt_settle_timer
  import tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // reload on request, else count down to zero and stop
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/tt_sweeper.sv
// tt_sweeper: drives every input vector to a
// combinational DUT and compares its truth table.
module tt_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   result,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_fail
);

  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);
  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [NV-1:0]   result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mismatch_q, mismatch_d;
  logic [N_IN-1:0] ff_q, ff_d;

  logic [NV-1:0]   diff;
  logic [N_IN-1:0] ff_c;
  logic            tmr_load;
  logic            tmr_exp;

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LOAD_V),
    .expired  (tmr_exp)
  );

  assign diff = result_q ^ expected;

  // lowest differing vector index wins
  always_comb begin
    ff_c = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (diff[i]) begin
        ff_c = N_IN'(i);
      end
    end
  end

  // sweep sequencing and output updates
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;
    ff_d       = ff_q;
    tmr_load   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          idx_d      = '0;
          result_d   = '0;
          mismatch_d = 1'b0;
          ff_d       = '0;
          busy_d     = 1'b1;
          tmr_load   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_exp) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        result_d[idx_q] = dut_out;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          state_d  = ST_SETTLE;
          idx_d    = idx_q + 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        mismatch_d = |diff;
        ff_d       = ff_c;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      ff_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      ff_q       <= ff_d;
    end
  end

  assign dut_in     = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign mismatch   = mismatch_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_tt_sweeper.sv
// tb_tt_sweeper: sweeps a 2-input and a
// 3-input DUT against a truth-table model.
module tb_tt_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic [3:0] exp_a;
  logic [7:0] exp_b;
  logic [1:0] din_a;
  logic [2:0] din_b;
  logic       out_a, out_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;
  logic [3:0] res_a;
  logic [7:0] res_b;
  logic       mm_a, mm_b;
  logic [1:0] ff_a;
  logic [2:0] ff_b;

  assign out_a = din_a[0] & ~din_a[1];
  assign out_b = ^din_b;

  tt_sweeper u_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .expected   (exp_a),
    .dut_in     (din_a),
    .dut_out    (out_a),
    .busy       (busy_a),
    .done       (done_a),
    .result     (res_a),
    .mismatch   (mm_a),
    .first_fail (ff_a)
  );

  tt_sweeper #(.N_IN(3), .SETTLE(3)) u_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .expected   (exp_b),
    .dut_in     (din_b),
    .dut_out    (out_b),
    .busy       (busy_b),
    .done       (done_b),
    .result     (res_b),
    .mismatch   (mm_b),
    .first_fail (ff_b)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic snap(input bit b,
                      output logic [2:0] di,
                      output logic bz,
                      output logic dn,
                      output logic mm,
                      output logic [7:0] rs,
                      output logic [2:0] ff);
    if (b) begin
      di = din_b; bz = busy_b; dn = done_b;
      mm = mm_b; rs = res_b; ff = ff_b;
    end else begin
      di = {1'b0, din_a}; bz = busy_a; dn = done_a;
      mm = mm_a; rs = {4'b0, res_a}; ff = {1'b0, ff_a};
    end
  endtask

  task automatic set_in(input bit b, input logic st,
                        input logic [7:0] ex);
    if (b) begin
      start_b = st; exp_b = ex;
    end else begin
      start_a = st; exp_a = ex[3:0];
    end
  endtask

  task automatic run_sweep(input bit b,
                           input logic [7:0] ex,
                           input bit noisy,
                           input string tag);
    int n, s, nv, lat, done_at, ndone;
    logic [7:0] tt, diff, mask;
    logic [2:0] ffm, di, ffv;
    logic [7:0] rs;
    logic bz, dn, mmv, mmm, st;
    logic [7:0] ex_now;
    bit din_ok, busy_ok;
    n = b ? 3 : 2;
    s = b ? 3 : 1;
    nv = 1 << n;
    lat = nv * (s + 1) + 1;
    mask = 8'((1 << nv) - 1);
    tt = '0;
    for (int i = 0; i < nv; i++) begin
      tt[i] = b ? ^(i[2:0]) : (i[0] & ~i[1]);
    end
    diff = (tt ^ ex) & mask;
    mmm = |diff;
    ffm = '0;
    for (int i = nv - 1; i >= 0; i--) begin
      if (diff[i]) ffm = i[2:0];
    end
    done_at = -1;
    ndone = 0;
    din_ok = 1'b1;
    busy_ok = 1'b1;
    @(negedge clk);
    set_in(b, 1'b1, ex);
    for (int k = 0; k <= lat + 3; k++) begin
      @(negedge clk);
      snap(b, di, bz, dn, mmv, rs, ffv);
      if (k < nv * (s + 1)) begin
        if (di !== 3'(k / (s + 1))) din_ok = 1'b0;
      end else if (di !== 3'd0) begin
        din_ok = 1'b0;
      end
      if (bz !== (k < lat)) busy_ok = 1'b0;
      if (dn === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      st = (noisy && k <= lat - 1) ? 1'($urandom % 2) : 1'b0;
      ex_now = (noisy && k < lat - 2) ? 8'($urandom) : ex;
      set_in(b, st, ex_now);
    end
    snap(b, di, bz, dn, mmv, rs, ffv);
    check({tag, ".done_at"}, done_at, lat);
    check({tag, ".ndone"}, ndone, 1);
    check({tag, ".din_seq"}, 32'(din_ok), 1);
    check({tag, ".busy_seq"}, 32'(busy_ok), 1);
    check({tag, ".result"}, rs, tt);
    check({tag, ".mismatch"}, mmv, mmm);
    check({tag, ".first_fail"}, ffv, ffm);
  endtask

  initial begin
    logic [2:0] di, ffv;
    logic [7:0] rs;
    logic bz, dn, mmv;
    int ndone;
    bit b;
    logic [7:0] ex;

    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'h0);
    set_in(1'b1, 1'b0, 8'h0);
    repeat (3) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      snap(j[0], di, bz, dn, mmv, rs, ffv);
      check("rst.din", di, 0);
      check("rst.busy", bz, 0);
      check("rst.done", dn, 0);
      check("rst.result", rs, 0);
      check("rst.mismatch", mmv, 0);
      check("rst.first_fail", ffv, 0);
    end
    rst = 1'b0;

    run_sweep(1'b0, 8'b0010, 1'b0, "a_pass");
    run_sweep(1'b0, 8'b0110, 1'b0, "a_fail");
    run_sweep(1'b0, 8'b0010, 1'b1, "a_noisy");

    @(negedge clk);
    set_in(1'b0, 1'b1, 8'b0010);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      set_in(1'b0, 1'b0, 8'b0010);
    end
    check("abort.pre_result", res_a, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy", busy_a, 0);
    check("abort.result", res_a, 0);
    check("abort.din", din_a, 0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_a !== 1'b0) ndone++;
    end
    check("abort.no_done", ndone, 0);

    rst = 1'b1;
    set_in(1'b0, 1'b1, 8'b0010);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 8'b0010);
    @(negedge clk);
    check("rst_prio.busy", busy_a, 0);

    run_sweep(1'b0, 8'b0010, 1'b0, "a_after_rst");
    run_sweep(1'b1, 8'b10010110, 1'b0, "b_parity");

    for (int r = 0; r < 8; r++) begin
      b = 1'($urandom % 2);
      ex = b ? 8'($urandom) : 8'($urandom % 16);
      run_sweep(b, ex, 1'($urandom % 2), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tt_sweeper.md
TT_SWEEPER -- requirements
Module: tt_sweeper

Interface
REQ-001 Parameter N_IN, default 2: number of DUT inputs; legal range 1..6.
REQ-002 Parameter SETTLE, default 1: cycles each vector is held before sampling; legal range 1..15.
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port start  input  1: request a full truth-table sweep; sampled only in IDLE.
REQ-006 Port expected  input  2**N_IN: golden truth table, bit i = expected DUT output for input vector i.
REQ-007 Port dut_in  output  N_IN: vector driven to the combinational DUT under test.
REQ-008 Port dut_out  input  1: DUT response.
REQ-009 Port busy  output  1: high while a sweep is in progress.
REQ-010 Port done  output  1: one-cycle pulse at sweep completion.
REQ-011 Port result  output  2**N_IN: captured truth table, bit i = dut_out sampled for vector i.
REQ-012 Port mismatch  output  1: result differs from expected; valid from done onward.
REQ-013 Port first_fail  output  N_IN: lowest index i where result[i] != expected[i]; 0 when mismatch=0.

Function
REQ-014 FSM states: IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-015 IDLE with start=1 transitions to SETTLE and sets: idx=0, dut_in=0, result=0, mismatch=0, first_fail=0, busy=1.
REQ-016 SETTLE: dut_in holds idx for exactly SETTLE cycles, then the FSM moves to SAMPLE.
REQ-017 SAMPLE, one cycle: result[idx] <= dut_out.
REQ-018 SAMPLE with idx < 2**N_IN-1: idx and dut_in increment by 1, settle count reloads, next state SETTLE.
REQ-019 SAMPLE with idx = 2**N_IN-1: next state DONE, idx wraps to 0, dut_in returns to 0.
REQ-020 DONE, one cycle: done=1, busy=0, mismatch=|(result ^ expected), first_fail=lowest set bit index of (result ^ expected); next state IDLE.
REQ-021 Vectors are driven in ascending binary order, dut_in[N_IN-1] being the MSB.
REQ-022 Timing: done is high in the cycle after the edge that is 2**N_IN*(SETTLE+1)+1 edges after the edge that sampled start; for defaults, 9 edges.
REQ-023 start while busy=1 or in DONE is ignored; it does not restart or extend the sweep.
REQ-024 start held high across DONE->IDLE begins a new sweep on the first IDLE cycle.
REQ-025 expected is sampled only in DONE; changes during the sweep have no effect.
REQ-026 result, mismatch and first_fail hold their values in IDLE until the next accepted start.

Reset
REQ-027 rst=1 at a clock edge forces IDLE, with dut_in=0, busy=0, done=0, result=0, mismatch=0, first_fail=0, idx=0 and settle count=0.
REQ-028 rst asserted mid-sweep aborts the sweep with no done pulse; the next start after rst deasserts begins a fresh sweep from vector 0.
REQ-029 rst takes priority over start in the same cycle.

Structure
REQ-030 Shared package tt_pkg holds: the FSM state enum (IDLE, SETTLE, SAMPLE, DONE), default N_IN/SETTLE constants, and the settle-counter width constant (4 bits).
REQ-031 One sub-module, tt_settle_timer: loadable down-counter with a load input and an expired output, same clk/rst; the FSM uses it for SETTLE timing.
REQ-032 first_fail is derived by a combinational priority encoder on result ^ expected, registered in DONE.

Verification
REQ-033 Bench DUT model: dut_out = dut_in[0] & ~dut_in[1] (y & ~x, with x=dut_in[1], y=dut_in[0]).
REQ-034 Defaults, expected=4'b0010, start pulse -> dut_in sequence 0,1,2,3 with each value held 2 cycles; done 9 edges after start; result=4'b0010, mismatch=0, first_fail=0.
REQ-035 expected=4'b0110 -> result=4'b0010, mismatch=1, first_fail=2.
REQ-036 Extra start pulses during busy -> only one done pulse, same timing as REQ-034.
REQ-037 rst asserted on the 5th cycle of a sweep -> busy=0, result=0 and dut_in=0 the next cycle, no done pulse; the following start yields a full 9-edge sweep.
REQ-038 SETTLE=3, N_IN=3, DUT model dut_out=^dut_in, expected=8'b10010110 -> done after 33 edges, mismatch=0.
